// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment glyph constants and decode function
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Active-low gfedcba pattern for one nibble; letters only in hex mode.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble, input logic hex_mode);
    logic [6:0] g;
    case (nibble)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = hex_mode ? GLYPH_A : SEG_BLANK;
      4'hB: g = hex_mode ? GLYPH_B : SEG_BLANK;
      4'hC: g = hex_mode ? GLYPH_C : SEG_BLANK;
      4'hD: g = hex_mode ? GLYPH_D : SEG_BLANK;
      4'hE: g = hex_mode ? GLYPH_E : SEG_BLANK;
      default: g = hex_mode ? GLYPH_F : SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// rtl/seg7_glyph_rom.sv - combinational nibble to segment pattern lookup
module seg7_glyph_rom
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = seg7_glyph(nibble, HEX_MODE != 0);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - frame-synchronous multiplexed seven-segment scanner
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 50000,
  parameter int HEX_MODE       = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              segments,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   anodes_n,
  output logic                    frame_start
);

  localparam int PRE_W = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        idx;
  logic                    tc;
  logic                    boundary;
  logic                    boundary_q;
  logic [4*NUM_DIGITS-1:0] pend_value;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_valid;
  logic [4*NUM_DIGITS-1:0] disp_value;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic [3:0]              cur_nibble;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   cur_onehot;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    higher_zero;
  logic [6:0]              rom_seg;
  logic [6:0]              cur_seg;

  assign tc       = (prescaler == PRE_LAST);
  assign boundary = tc && (idx == IDX_LAST);

  // Slot timing: prescaler wraps every digit slot, idx walks the digits.
  // boundary_q delays the wrap so frame_start lines up with the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      boundary_q <= 1'b0;
    end else begin
      boundary_q <= boundary;
      if (tc) begin
        prescaler <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Loads park in pending and only reach the display at a frame boundary, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
    end else if (load && boundary) begin
      disp_value <= value;
      disp_dp    <= dp_in;
      pend_valid <= 1'b0;
    end else if (boundary && pend_valid) begin
      disp_value <= pend_value;
      disp_dp    <= pend_dp;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp_in;
      pend_valid <= 1'b1;
    end
  end

  // Select the active digit and build the leading-zero mask, scanning from the top digit down.
  always_comb begin
    cur_nibble  = 4'd0;
    cur_dp      = 1'b0;
    cur_onehot  = '0;
    blank_mask  = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higher_zero   = higher_zero && (disp_value[4*k +: 4] == 4'd0);
      blank_mask[k] = (BLANK_LEADING != 0) && (k != 0) && higher_zero;
      if (idx == IDX_W'(k)) begin
        cur_nibble    = disp_value[4*k +: 4];
        cur_dp        = disp_dp[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  seg7_glyph_rom #(
    .HEX_MODE (HEX_MODE)
  ) u_glyph_rom (
    .nibble   (cur_nibble),
    .segments (rom_seg)
  );

  assign cur_seg = (|(blank_mask & cur_onehot)) ? SEG_BLANK : rom_seg;

  // Registered pin drivers; enable only darkens the pins, scan timing is untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      segments    <= SEG_BLANK;
      dp_n        <= 1'b1;
      anodes_n    <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary_q;
      if (enable) begin
        segments <= cur_seg;
        dp_n     <= ~cur_dp;
        anodes_n <= ~cur_onehot;
      end else begin
        segments <= SEG_BLANK;
        dp_n     <= 1'b1;
        anodes_n <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench against a time-based display model
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int C  = 4;
  localparam int OW = 7 + 1 + N + 1;
  localparam logic [OW-1:0] RST_OUT = {7'h7F, 1'b1, {N{1'b1}}, 1'b0};

  logic clk = 1'b0;
  logic rst, load, enable;
  logic [4*N-1:0] value;
  logic [N-1:0]   dp_in;

  logic [6:0]   seg_h, seg_d, seg_n;
  logic         dpn_h, dpn_d, dpn_n;
  logic [N-1:0] an_h, an_d, an_n;
  logic         fs_h, fs_d, fs_n;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: edges since reset release plus display/pending contents.
  int           m_cyc;
  logic [4*N-1:0] m_disp, m_pend;
  logic [N-1:0] m_dp, m_pdp;
  bit           m_pv;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .CLKS_PER_DIGIT(C), .HEX_MODE(1), .BLANK_LEADING(1)) dut_hex (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .segments(seg_h), .dp_n(dpn_h), .anodes_n(an_h), .frame_start(fs_h));

  seg7_scan_driver #(.NUM_DIGITS(N), .CLKS_PER_DIGIT(C), .HEX_MODE(0), .BLANK_LEADING(1)) dut_dec (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .segments(seg_d), .dp_n(dpn_d), .anodes_n(an_d), .frame_start(fs_d));

  seg7_scan_driver #(.NUM_DIGITS(N), .CLKS_PER_DIGIT(C), .HEX_MODE(1), .BLANK_LEADING(0)) dut_nob (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .enable(enable),
    .segments(seg_n), .dp_n(dpn_n), .anodes_n(an_n), .frame_start(fs_n));

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got %b expected %b (seg,dp_n,anodes_n,frame_start)", tag, m_cyc, got, exp);
    end
  endtask

  // Expected pins for the edge about to happen, from slot arithmetic on elapsed cycles.
  function automatic logic [OW-1:0] model_out(input bit hex, input bit blank);
    int d;
    logic [3:0] nib;
    logic [6:0] s;
    logic [N-1:0] an;
    logic dpn, fs;
    d   = (m_cyc / C) % N;
    nib = 4'((m_disp >> (4 * d)) & 16'hF);
    s   = (hex || nib < 4'd10) ? glyph_tab[nib] : 7'h7F;
    if (blank && d > 0 && (m_disp >> (4 * d)) == 0) s = 7'h7F;
    an  = ~(N'(1) << d);
    dpn = ~m_dp[d];
    if (!enable) begin
      s   = 7'h7F;
      dpn = 1'b1;
      an  = '1;
    end
    fs = (m_cyc > 0) && (m_cyc % (N * C) == 0);
    return {s, dpn, an, fs};
  endfunction

  task automatic tick();
    logic [OW-1:0] eh, ed, en;
    bit bnd;
    if (rst) begin
      eh = RST_OUT; ed = RST_OUT; en = RST_OUT;
      m_cyc = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pv = 0;
    end else begin
      eh = model_out(1, 1);
      ed = model_out(0, 1);
      en = model_out(1, 0);
      bnd = ((m_cyc + 1) % (N * C)) == 0;
      if (load && bnd) begin
        m_disp = value; m_dp = dp_in; m_pv = 0;
      end else if (bnd && m_pv) begin
        m_disp = m_pend; m_dp = m_pdp; m_pv = 0;
      end else if (load) begin
        m_pend = value; m_pdp = dp_in; m_pv = 1;
      end
      m_cyc++;
    end
    @(posedge clk);
    #1;
    check("hex_blank", {seg_h, dpn_h, an_h, fs_h}, eh);
    check("dec_blank", {seg_d, dpn_d, an_d, fs_d}, ed);
    check("hex_noblank", {seg_n, dpn_n, an_n, fs_n}, en);
  endtask

  task automatic load_once(input logic [4*N-1:0] v, input logic [N-1:0] dp);
    value = v; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enable = 1'b1; value = '0; dp_in = '0;
    m_cyc = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pv = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    load_once(16'h12AF, 4'b0000);
    repeat (40) tick();

    load_once(16'h00C5, 4'b0000);
    repeat (36) tick();

    load_once(16'h1111, 4'b0001);
    repeat (2) tick();
    load_once(16'h2222, 4'b0010);
    repeat (36) tick();

    while (((m_cyc + 1) % (N * C)) != 0) tick();
    load_once(16'h0907, 4'b1000);
    repeat (20) tick();

    load_once(16'h0042, 4'b0100);
    repeat (20) tick();
    enable = 1'b0;
    repeat (10) tick();
    enable = 1'b1;
    repeat (20) tick();

    while ((m_cyc % (N * C)) != 3) tick();
    load_once(16'h8888, 4'b1111);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) tick();

    for (int i = 0; i < 1500; i++) begin
      load  = ($urandom_range(0, 9) == 0);
      value = 16'($urandom) >> (4 * $urandom_range(0, 3));
      dp_in = 4'($urandom);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      rst   = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
    repeat (20) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It latches a packed multi-digit value, then scans one digit per refresh slot. For each digit it drives the active-low segment pattern, decimal point and digit enable. It supports hex or decimal glyph sets and optional leading-zero blanking. Display updates are frame-synchronous, so a digit never tears mid-scan. The block sits between the numeric datapath and the board-level display pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- CLKS_PER_DIGIT, 50000, clock cycles each digit is lit (≥2)
- HEX_MODE, 1, 1: nibbles 10..15 show A,b,C,d,E,F; 0: nibbles 10..15 show blank
- BLANK_LEADING, 1, 1: blank zero digits above the most significant nonzero digit

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- value  in  4*NUM_DIGITS  packed nibbles, digit 0 = bits [3:0] (rightmost)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- load  in  1  one-cycle strobe, captures value/dp_in
- enable  in  1  0 = all digits dark, scan keeps running
- segments  out  7  gfedcba, active low
- dp_n  out  1  decimal point, active low
- anodes_n  out  NUM_DIGITS  digit enable, active low, one-hot-low
- frame_start  out  1  one-cycle pulse when digit 0 begins a slot

## Operation
- Prescaler counts 0..CLKS_PER_DIGIT-1 and wraps. Terminal count (tc) advances the digit index idx, wrapping NUM_DIGITS-1 → 0.
- Frame boundary: tc while idx = NUM_DIGITS-1.
- load captures value and dp_in into the pending register and sets pend_valid. A later load before the boundary overwrites pending (last write wins).
- At a frame boundary with pend_valid: display register ← pending, pend_valid ← 0.
- If load coincides with a frame boundary, the incoming value/dp_in go directly to the display register and pend_valid is cleared.
- Glyphs (gfedcba, active low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000
  - A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110
  - blank 1111111
- Leading blanking, when enabled: digit k is blank if it and all higher digits are 0. Digit 0 is never blanked. A blanked digit still shows its dp.
- enable = 0: segments = 7'h7F, dp_n = 1, anodes_n all 1. idx and prescaler are unaffected.

## Timing
- All outputs are registered. They reflect idx and the display register from the previous cycle.
- Reset values (held while rst is high):
  - prescaler 0, idx 0
  - display and pending registers 0, pend_valid 0
  - segments 7'h7F, dp_n 1, anodes_n all 1, frame_start 0
- First edge after rst deasserts: outputs show digit 0 of the zeroed display, i.e. segments 1000000 and anodes_n bit 0 low (with enable = 1).
- Each digit is driven for exactly CLKS_PER_DIGIT cycles.
- frame_start is high for the first cycle that digit 0 is driven after a wrap. It is not asserted for the initial post-reset slot.
- Latency from load to visible: up to one full frame (NUM_DIGITS*CLKS_PER_DIGIT cycles) plus 1 cycle.
- Mid-operation rst: all state returns to reset values on that edge and any pending load is lost.

## Structure
- Shared package seg7_pkg:
  - SEG_BLANK constant
  - glyph constants 0..F
  - function seg7_glyph(nibble, hex_mode) returning 7 bits
- Sub-module seg7_glyph_rom: combinational nibble → segments, with HEX_MODE parameter. Instantiated once on the muxed nibble.
- Prescaler, index counter, pending/display registers, blanking mask and output registers live in the top module.

## Test plan
All scenarios use NUM_DIGITS=4, CLKS_PER_DIGIT=4.
- Reset release, no load → segments 1000000 on digit 0 only. Digits 1..3 blank under BLANK_LEADING. anodes_n sequence 1110, 1101, 1011, 0111, each held 4 cycles.
- load value=16'h12AF, HEX_MODE=1 → after next frame_start, digits 0..3 show F, A, 2, 1. No change is visible before that frame boundary.
- HEX_MODE=0, BLANK_LEADING=1, load 16'h00C5:
  - digit 0 shows 0010010
  - digit 1 shows blank (nibble C is out of range in decimal mode)
  - digits 2..3 show blank (leading zeros)
- Two loads in one frame (16'h1111, then 16'h2222) → next frame shows 2222 only. Load asserted on the boundary cycle → that value is displayed in the immediately following frame.
- dp_in=4'b0100, enable toggled low for 10 cycles → dp_n is low only during the digit-2 slot. While enable is low, outputs are all 1. Slot timing and frame_start continue uninterrupted.
- rst asserted mid-frame with pend_valid set → outputs go to reset values next edge. After release the display shows zeros, and the pending value never appears.
